// File: rtl/awg_sig_gen_if.sv
// awg_sig_gen_if: front-panel control fields into the generator, DAC channel A data and strobes out.
interface awg_sig_gen_if;
  logic [4:0]  state;
  logic [11:0] state_freq;
  logic [2:0]  state_amp;
  logic [7:0]  state_phase;
  logic [13:0] DA_A;
  logic        DA_CLK_A;
  logic        DA_WR_A;
  modport master (
    output state, state_freq, state_amp, state_phase,
    input  DA_A, DA_CLK_A, DA_WR_A
  );
  modport slave (
    input  state, state_freq, state_amp, state_phase,
    output DA_A, DA_CLK_A, DA_WR_A
  );
endinterface

// File: rtl/awg_sig_gen.sv
// awg_sig_gen: single-channel DDS generator feeding a 14-bit offset-binary DAC at clk/2.
// Defining AWG_TICK_EN adds the TICK_CYCLES parameter and the registered tick_1s pulse output.
module awg_sig_gen #(
  parameter int ACC_W      = 32,
  parameter int FREQ_SHIFT = 12
`ifdef AWG_TICK_EN
  , parameter int TICK_CYCLES = 50_000_000
`endif
) (
  input  logic          clk,
  input  logic          rst_n,
  awg_sig_gen_if.slave  bus
`ifdef AWG_TICK_EN
  , output logic        tick_1s
`endif
);
  // quarter-wave table sampled at bin centres, so no entry lands exactly on 0 or full scale
  localparam logic [12:0] LUT [64] = '{
    13'd101,  13'd301,  13'd502,  13'd703,  13'd903,  13'd1102, 13'd1301, 13'd1499,
    13'd1696, 13'd1893, 13'd2088, 13'd2281, 13'd2474, 13'd2665, 13'd2854, 13'd3041,
    13'd3227, 13'd3411, 13'd3593, 13'd3772, 13'd3950, 13'd4124, 13'd4297, 13'd4467,
    13'd4634, 13'd4798, 13'd4960, 13'd5118, 13'd5274, 13'd5426, 13'd5575, 13'd5720,
    13'd5863, 13'd6001, 13'd6136, 13'd6267, 13'd6395, 13'd6519, 13'd6638, 13'd6754,
    13'd6866, 13'd6973, 13'd7077, 13'd7176, 13'd7271, 13'd7361, 13'd7447, 13'd7528,
    13'd7605, 13'd7678, 13'd7745, 13'd7809, 13'd7867, 13'd7921, 13'd7969, 13'd8013,
    13'd8053, 13'd8087, 13'd8116, 13'd8141, 13'd8161, 13'd8176, 13'd8185, 13'd8190
  };
  logic              t;
  logic              strobe;
  logic [ACC_W-1:0]  acc;
  logic [13:0]       da;
  logic [11:0]       p;
  logic [5:0]        idx;
  logic [12:0]       mag;
  logic [10:0]       u;
  logic signed [13:0] raw;
  logic signed [13:0] inv;
  logic signed [13:0] sc;
  always_comb begin
    p   = acc[ACC_W-1 -: 12] + {bus.state_phase, 4'b0};
    idx = p[10] ? ~p[9:4] : p[9:4];
    mag = LUT[idx];
    u   = p[11] ? ~p[10:0] : p[10:0];
    raw = bus.state[2:0] == 3'd1 ? (p[11] ? -$signed({1'b0, mag}) : $signed({1'b0, mag})) :
          bus.state[2:0] == 3'd2 ? (p[11] ? -14'sd8191 : 14'sd8191) :
          bus.state[2:0] == 3'd3 ? $signed({u, 3'b0}) - 14'sd8188 :
          bus.state[2:0] == 3'd4 ? $signed({~p[11], p[10:0], 2'b0}) : 14'sd0;
    inv = !bus.state[3] ? raw : raw == 14'sh2000 ? 14'sd8191 : -raw;
    sc  = inv >>> bus.state_amp;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      t      <= 1'b0;
      strobe <= 1'b0;
      acc    <= '0;
      da     <= 14'h2000;
    end else begin
      t      <= ~t;
      strobe <= t;
      if (!t) begin
        acc <= bus.state[4] ? acc + (ACC_W'(bus.state_freq) << FREQ_SHIFT) : '0;
        da  <= bus.state[4] ? {~sc[13], sc[12:0]} : 14'h2000;
      end
    end
  assign bus.DA_A     = da;
  assign bus.DA_CLK_A = strobe;
  assign bus.DA_WR_A  = strobe;
`ifdef AWG_TICK_EN
  localparam int CNT_W = $clog2(TICK_CYCLES);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk)
    if (!rst_n) begin
      cnt     <= '0;
      tick_1s <= 1'b0;
    end else begin
      cnt     <= cnt == CNT_W'(TICK_CYCLES - 1) ? '0 : cnt + CNT_W'(1);
      tick_1s <= cnt == CNT_W'(TICK_CYCLES - 1);
    end
`endif
endmodule

// File: tb/tb_awg_sig_gen.sv
// tb_awg_sig_gen: scoreboard bench; expected DAC words are queued when inputs are applied and popped at each update edge.
module tb_awg_sig_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  awg_sig_gen_if bus();
`ifdef AWG_TICK_EN
  logic tick_1s;
  awg_sig_gen #(.TICK_CYCLES(10)) dut (.clk(clk), .rst_n(rst_n), .bus(bus), .tick_1s(tick_1s));
`else
  awg_sig_gen dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif
  int n_checks = 0;
  int n_fail = 0;
  logic [13:0] sb [$];
  logic [31:0] m_acc = '0;
  logic [13:0] got, exp_v, prev;

  function automatic logic [13:0] model(logic [31:0] acc, logic [4:0] st, logic [2:0] amp, logic [7:0] ph);
    int p, q, i, m, u, s;
    if (!st[4]) return 14'h2000;
    p = (int'(acc[31:20]) + int'(ph) * 16) % 4096;
    q = (p / 16) % 64;
    i = (p % 2048) >= 1024 ? 63 - q : q;
    m = $rtoi(8191.0 * $sin(3.14159265358979 * (real'(i) + 0.5) / 128.0) + 0.5);
    u = p >= 2048 ? 4095 - p : p;
    case (st[2:0])
      3'd1: s = p >= 2048 ? -m : m;
      3'd2: s = p >= 2048 ? -8191 : 8191;
      3'd3: s = 8 * u - 8188;
      3'd4: s = 4 * p - 8192;
      default: s = 0;
    endcase
    if (st[3]) s = (s == -8192) ? 8191 : -s;
    s = s >>> amp;
    return 14'(s + 8192);
  endfunction

  task automatic set_in(input logic [4:0] st, input logic [11:0] f, input logic [2:0] a, input logic [7:0] ph);
    bus.state = st;
    bus.state_freq = f;
    bus.state_amp = a;
    bus.state_phase = ph;
  endtask

  task automatic issue(input logic use_k, input logic [13:0] k);
    sb.push_back(use_k ? k : model(m_acc, bus.state, bus.state_amp, bus.state_phase));
    m_acc = bus.state[4] ? m_acc + ({20'b0, bus.state_freq} << 12) : 32'd0;
    @(posedge clk);
    #1;
  endtask

  task automatic half();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    set_in(5'b0, 12'd0, 3'd0, 8'd0);
    rst_n = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_checks++; if (bus.DA_A !== 14'h2000) begin n_fail++; $display("FAIL rst_da got=%h exp=2000", bus.DA_A); end
    n_checks++; if (bus.DA_CLK_A !== 1'b0) begin n_fail++; $display("FAIL rst_clk got=%b exp=0", bus.DA_CLK_A); end
    n_checks++; if (bus.DA_WR_A !== 1'b0) begin n_fail++; $display("FAIL rst_wr got=%b exp=0", bus.DA_WR_A); end
`ifdef AWG_TICK_EN
    n_checks++; if (tick_1s !== 1'b0) begin n_fail++; $display("FAIL rst_tick got=%b exp=0", tick_1s); end
`endif
    rst_n = 1'b1;
    m_acc = '0;
    for (int e = 0; e < 4; e++) begin
      half();
      n_checks++; if (bus.DA_CLK_A !== 1'(e % 2)) begin n_fail++; $display("FAIL strobe_clk e=%0d got=%b exp=%b", e, bus.DA_CLK_A, 1'(e % 2)); end
      n_checks++; if (bus.DA_WR_A !== 1'(e % 2)) begin n_fail++; $display("FAIL strobe_wr e=%0d got=%b exp=%b", e, bus.DA_WR_A, 1'(e % 2)); end
      n_checks++; if (bus.DA_A !== 14'h2000) begin n_fail++; $display("FAIL idle_da e=%0d got=%h exp=2000", e, bus.DA_A); end
    end
  endtask

  task automatic test_square();
    logic [4:0]  st [4] = '{5'b10010, 5'b10010, 5'b10010, 5'b11010};
    logic [2:0]  am [4] = '{3'd0, 3'd0, 3'd3, 3'd3};
    logic [7:0]  ph [4] = '{8'h00, 8'h80, 8'h00, 8'h00};
    logic [13:0] ex [4] = '{14'h3FFF, 14'h0001, 14'h23FF, 14'h1C00};
    for (int k = 0; k < 4; k++) begin
      set_in(st[k], 12'd1, am[k], ph[k]);
      issue(1'b1, ex[k]);
      got = bus.DA_A;
      exp_v = sb.pop_front();
      n_checks++; if (got !== exp_v) begin n_fail++; $display("FAIL square k=%0d got=%h exp=%h", k, got, exp_v); end
      n_checks++; if (bus.DA_CLK_A !== 1'b0) begin n_fail++; $display("FAIL square_clk k=%0d got=%b exp=0", k, bus.DA_CLK_A); end
      half();
    end
  endtask

  task automatic test_sine_tri();
    set_in(5'b10001, 12'd0, 3'd0, 8'h00);
    issue(1'b1, 14'd8293);
    got = bus.DA_A; exp_v = sb.pop_front();
    n_checks++; if (got !== exp_v) begin n_fail++; $display("FAIL sine_zero got=%0d exp=%0d", got, exp_v); end
    half();
    set_in(5'b10011, 12'd0, 3'd0, 8'h40);
    issue(1'b1, 14'd8196);
    got = bus.DA_A; exp_v = sb.pop_front();
    n_checks++; if (got !== exp_v) begin n_fail++; $display("FAIL tri_q got=%0d exp=%0d", got, exp_v); end
    half();
    for (int ph = 0; ph < 256; ph++) begin
      set_in(5'b10001, 12'd0, 3'd0, 8'(ph));
      issue(1'b0, 14'd0);
      got = bus.DA_A; exp_v = sb.pop_front();
      n_checks++; if (got !== exp_v) begin n_fail++; $display("FAIL sine_sweep ph=%0d got=%0d exp=%0d", ph, got, exp_v); end
      half();
    end
  endtask

  task automatic test_latency();
    set_in(5'b10010, 12'd0, 3'd0, 8'h00);
    issue(1'b1, 14'h3FFF);
    got = bus.DA_A; exp_v = sb.pop_front();
    n_checks++; if (got !== exp_v) begin n_fail++; $display("FAIL lat_first got=%h exp=%h", got, exp_v); end
    bus.state_phase = 8'h80;
    half();
    n_checks++; if (bus.DA_A !== 14'h3FFF) begin n_fail++; $display("FAIL lat_hold got=%h exp=3fff", bus.DA_A); end
    issue(1'b1, 14'h0001);
    got = bus.DA_A; exp_v = sb.pop_front();
    n_checks++; if (got !== exp_v) begin n_fail++; $display("FAIL lat_next got=%h exp=%h", got, exp_v); end
    half();
  endtask

  task automatic test_saw();
    set_in(5'b00100, 12'd1, 3'd0, 8'h00);
    issue(1'b1, 14'h2000);
    got = bus.DA_A; exp_v = sb.pop_front();
    n_checks++; if (got !== exp_v) begin n_fail++; $display("FAIL saw_clear got=%h exp=%h", got, exp_v); end
    half();
    bus.state = 5'b10100;
    for (int n = 0; n < 3; n++) begin
      issue(1'b1, 14'h0000);
      got = bus.DA_A; exp_v = sb.pop_front();
      n_checks++; if (got !== exp_v) begin n_fail++; $display("FAIL saw_start n=%0d got=%h exp=%h", n, got, exp_v); end
      half();
    end
    bus.state_freq = 12'h800;
    prev = '0;
    for (int n = 0; n <= 512; n++) begin
      issue(1'b0, 14'd0);
      got = bus.DA_A; exp_v = sb.pop_front();
      n_checks++; if (got !== exp_v) begin n_fail++; $display("FAIL saw n=%0d got=%h exp=%h", n, got, exp_v); end
      if (n > 0 && n < 512) begin
        n_checks++; if (!(got > prev)) begin n_fail++; $display("FAIL saw_rise n=%0d got=%h prev=%h", n, got, prev); end
      end
      if (n == 512) begin
        n_checks++; if (got !== 14'h0000) begin n_fail++; $display("FAIL saw_wrap got=%h exp=0000", got); end
      end
      prev = got;
      half();
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 200; n++) begin
      set_in(5'($urandom) | 5'b10000 & 5'($urandom_range(0, 31) < 28 ? 31 : 15), 12'($urandom), 3'($urandom), 8'($urandom));
      issue(1'b0, 14'd0);
      got = bus.DA_A; exp_v = sb.pop_front();
      n_checks++; if (got !== exp_v) begin n_fail++; $display("FAIL rand n=%0d st=%b f=%h a=%0d ph=%h got=%h exp=%h", n, bus.state, bus.state_freq, bus.state_amp, bus.state_phase, got, exp_v); end
      half();
    end
  endtask

  task automatic test_stop();
    set_in(5'b00010, 12'h123, 3'd0, 8'h00);
    for (int n = 0; n < 2; n++) begin
      issue(1'b1, 14'h2000);
      got = bus.DA_A; exp_v = sb.pop_front();
      n_checks++; if (got !== exp_v) begin n_fail++; $display("FAIL stop n=%0d got=%h exp=%h", n, got, exp_v); end
      n_checks++; if (bus.DA_CLK_A !== 1'b0) begin n_fail++; $display("FAIL stop_clk0 got=%b exp=0", bus.DA_CLK_A); end
      half();
      n_checks++; if (bus.DA_CLK_A !== 1'b1) begin n_fail++; $display("FAIL stop_clk1 got=%b exp=1", bus.DA_CLK_A); end
    end
    set_in(5'b10010, 12'd0, 3'd0, 8'h00);
    issue(1'b1, 14'h3FFF);
    got = bus.DA_A; exp_v = sb.pop_front();
    n_checks++; if (got !== exp_v) begin n_fail++; $display("FAIL stop_cleared got=%h exp=%h", got, exp_v); end
    half();
  endtask

  task automatic test_midreset();
    set_in(5'b10100, 12'hABC, 3'd2, 8'h11);
    for (int n = 0; n < 3; n++) begin
      issue(1'b0, 14'd0);
      got = bus.DA_A; exp_v = sb.pop_front();
      n_checks++; if (got !== exp_v) begin n_fail++; $display("FAIL pre_rst n=%0d got=%h exp=%h", n, got, exp_v); end
      if (n < 2) half();
    end
    rst_n = 1'b0;
    half();
    n_checks++; if (bus.DA_A !== 14'h2000) begin n_fail++; $display("FAIL mid_rst_da got=%h exp=2000", bus.DA_A); end
    n_checks++; if (bus.DA_CLK_A !== 1'b0 || bus.DA_WR_A !== 1'b0) begin n_fail++; $display("FAIL mid_rst_strobe got=%b%b exp=00", bus.DA_CLK_A, bus.DA_WR_A); end
    rst_n = 1'b1;
    m_acc = '0;
    issue(1'b0, 14'd0);
    got = bus.DA_A; exp_v = sb.pop_front();
    n_checks++; if (got !== exp_v) begin n_fail++; $display("FAIL post_rst got=%h exp=%h", got, exp_v); end
    half();
  endtask

`ifdef AWG_TICK_EN
  task automatic test_tick();
    int last = -1;
    int pulses = 0;
    for (int c = 0; c < 40; c++) begin
      half();
      if (tick_1s === 1'b1) begin
        if (last >= 0) begin
          n_checks++; if (c - last !== 10) begin n_fail++; $display("FAIL tick_gap got=%0d exp=10", c - last); end
        end
        last = c;
        pulses++;
      end
    end
    n_checks++; if (pulses !== 4) begin n_fail++; $display("FAIL tick_count got=%0d exp=4", pulses); end
    set_in(5'b00001, 12'h7FF, 3'd0, 8'h00);
    issue(1'b1, 14'h2000);
    got = bus.DA_A; exp_v = sb.pop_front();
    n_checks++; if (got !== exp_v) begin n_fail++; $display("FAIL tick_stop got=%h exp=%h", got, exp_v); end
    half();
  endtask
`endif

  initial begin
    test_reset();
    test_square();
    test_sine_tri();
    test_latency();
    test_saw();
    test_random();
    test_stop();
    test_midreset();
`ifdef AWG_TICK_EN
    test_tick();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
